// File: rtl/reg_file_sb.sv
// Multi-port integer register file with per-register write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic [ADDR_WIDTH:0]            pending_cnt,
    output logic                           sb_full
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(NREGS - 1);

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busyNext;
    logic [ADDR_WIDTH:0]   pendingCnt;
    logic                  wrHit;
    logic                  issueHit;
    logic                  cntUp;
    logic                  cntDown;

    // Decode writeback/issue and derive the next busy vector and count step.
    // A same-register issue beats the writeback clear: the new producer wins.
    always_comb begin
        wrHit    = wr_en && (wr_addr != '0);
        issueHit = issue_en && (issue_rd != '0);
        cntUp    = issueHit && !busy[issue_rd];
        cntDown  = wrHit && busy[wr_addr]
                   && !(issueHit && (issue_rd == wr_addr));
        busyNext = busy;
        if (wrHit) begin
            busyNext[wr_addr] = 1'b0;
        end
        if (issueHit) begin
            busyNext[issue_rd] = 1'b1;
        end
    end

    // Register array write port; x0 is never written outside of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wrHit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard bits and running popcount of pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            pendingCnt <= '0;
        end else begin
            busy <= busyNext;
            unique case ({cntUp, cntDown})
                2'b10:   pendingCnt <= pendingCnt + 1'b1;
                2'b01:   pendingCnt <= pendingCnt - 1'b1;
                default: pendingCnt <= pendingCnt;
            endcase
        end
    end

    assign pending_cnt = pendingCnt;
    assign sb_full     = (pendingCnt == FULL_CNT);

    for (genvar i = 0; i < NUM_RD; i++) begin : gRd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Combinational read of data and busy bit, x0 forced to zero.
        always_comb begin
            data = (addr == '0) ? '0 : regs[addr];
            bsy  = busy[addr];
`ifdef RF_BYPASS_EN
            if (wrHit && (wr_addr == addr)) begin
                data = wr_data;
                if (!(issueHit && (issue_rd == wr_addr))) begin
                    bsy = 1'b0;
                end
            end
`endif
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[i] = bsy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed-vector bench for reg_file_sb (default parameters).
// Bypass expectations follow RF_BYPASS_EN when it is defined.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rdAddr;
    logic [NR*DW-1:0] rdData;
    logic [NR-1:0]   rdBusy;
    logic            wrEn;
    logic [AW-1:0]   wrAddr;
    logic [DW-1:0]   wrData;
    logic            issueEn;
    logic [AW-1:0]   issueRd;
    logic [AW:0]     pendingCnt;
    logic            sbFull;

    int vecCnt = 0;
    int errCnt = 0;

    reg_file_sb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_RD    (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .rd_busy    (rdBusy),
        .wr_en      (wrEn),
        .wr_addr    (wrAddr),
        .wr_data    (wrData),
        .issue_en   (issueEn),
        .issue_rd   (issueRd),
        .pending_cnt(pendingCnt),
        .sb_full    (sbFull)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rdAddr = {a1, a0};
        #1;
    endtask

    task automatic idle();
        wrEn    = 1'b0;
        issueEn = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        issueRd = '0;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        wrEn   = 1'b1;
        wrAddr = a;
        wrData = d;
        tick();
        idle();
    endtask

    task automatic doIssue(input logic [AW-1:0] a);
        idle();
        issueEn = 1'b1;
        issueRd = a;
        tick();
        idle();
    endtask

    initial begin
        rst    = 1'b1;
        rdAddr = '0;
        idle();
        // reset must override concurrent write/issue
        wrEn    = 1'b1;
        wrAddr  = 5'd5;
        wrData  = 32'hFFFF_0000;
        issueEn = 1'b1;
        issueRd = 5'd6;
        tick();
        rst = 1'b0;
        idle();

        for (int a = 0; a < 32; a++) begin
            setRd(AW'(a), AW'(a));
            check($sformatf("rst_d0_x%0d", a), 64'(rdData[DW-1:0]), 64'h0);
            check($sformatf("rst_d1_x%0d", a), 64'(rdData[2*DW-1:DW]), 64'h0);
            check($sformatf("rst_b_x%0d", a), 64'(rdBusy), 64'h0);
        end
        check("rst_cnt", 64'(pendingCnt), 64'd0);
        check("rst_full", 64'(sbFull), 64'd0);

        // write/read
        doWrite(5'd5, 32'hDEAD_BEEF);
        setRd(5'd5, 5'd5);
        check("wr5_d0", 64'(rdData[DW-1:0]), 64'hDEAD_BEEF);
        check("wr5_d1", 64'(rdData[2*DW-1:DW]), 64'hDEAD_BEEF);
        doWrite(5'd0, 32'h1234);
        setRd(5'd0, 5'd5);
        check("wr0_d0", 64'(rdData[DW-1:0]), 64'h0);
        check("wr0_d1", 64'(rdData[2*DW-1:DW]), 64'hDEAD_BEEF);
        check("wr0_cnt", 64'(pendingCnt), 64'd0);

        // scoreboard basic
        doIssue(5'd7);
        setRd(5'd0, 5'd7);
        check("iss7_busy", 64'(rdBusy), 64'b10);
        check("iss7_cnt", 64'(pendingCnt), 64'd1);
        doWrite(5'd7, 32'h55);
        setRd(5'd7, 5'd0);
        check("clr7_busy", 64'(rdBusy), 64'b00);
        check("clr7_cnt", 64'(pendingCnt), 64'd0);
        check("clr7_data", 64'(rdData[DW-1:0]), 64'h55);

        // simultaneous set/clear
        doIssue(5'd9);
        idle();
        issueEn = 1'b1;
        issueRd = 5'd9;
        wrEn    = 1'b1;
        wrAddr  = 5'd9;
        wrData  = 32'hA;
        tick();
        idle();
        setRd(5'd9, 5'd9);
        check("sc9_busy", 64'(rdBusy), 64'b11);
        check("sc9_cnt", 64'(pendingCnt), 64'd1);
        check("sc9_data", 64'(rdData[DW-1:0]), 64'hA);
        doIssue(5'd0);
        setRd(5'd0, 5'd9);
        check("iss0_busy", 64'(rdBusy), 64'b10);
        check("iss0_cnt", 64'(pendingCnt), 64'd1);
        doIssue(5'd9);
        check("reiss9_cnt", 64'(pendingCnt), 64'd1);
        doWrite(5'd9, 32'hB);
        check("wr9_cnt", 64'(pendingCnt), 64'd0);
        doWrite(5'd12, 32'h3);
        setRd(5'd12, 5'd9);
        check("nob_cnt", 64'(pendingCnt), 64'd0);
        check("nob_data", 64'(rdData[DW-1:0]), 64'h3);
        check("nob_busy", 64'(rdBusy), 64'b00);

        // fill the scoreboard
        for (int a = 1; a < 32; a++) begin
            doIssue(AW'(a));
        end
        setRd(5'd31, 5'd1);
        check("fill_cnt", 64'(pendingCnt), 64'd31);
        check("fill_full", 64'(sbFull), 64'd1);
        check("fill_busy", 64'(rdBusy), 64'b11);
        doWrite(5'd3, 32'h33);
        check("fill_w3_cnt", 64'(pendingCnt), 64'd30);
        check("fill_w3_full", 64'(sbFull), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setRd(5'd5, 5'd3);
        check("frst_cnt", 64'(pendingCnt), 64'd0);
        check("frst_full", 64'(sbFull), 64'd0);
        check("frst_busy", 64'(rdBusy), 64'b00);
        check("frst_d0", 64'(rdData[DW-1:0]), 64'h0);
        doWrite(5'd3, 32'h44);
        setRd(5'd3, 5'd0);
        check("post_rst_cnt", 64'(pendingCnt), 64'd0);
        check("post_rst_data", 64'(rdData[DW-1:0]), 64'h44);

        // same-cycle write visibility
        doWrite(5'd4, 32'h11);
        doIssue(5'd4);
        setRd(5'd4, 5'd0);
        check("byp_pre_busy", 64'(rdBusy), 64'b01);
        wrEn   = 1'b1;
        wrAddr = 5'd4;
        wrData = 32'h77;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_same_data", 64'(rdData[DW-1:0]), 64'h77);
        check("byp_same_busy", 64'(rdBusy), 64'b00);
`else
        check("byp_same_data", 64'(rdData[DW-1:0]), 64'h11);
        check("byp_same_busy", 64'(rdBusy), 64'b01);
`endif
        tick();
        idle();
        #1;
        check("byp_next_data", 64'(rdData[DW-1:0]), 64'h77);
        check("byp_next_busy", 64'(rdBusy), 64'b00);
        check("byp_next_cnt", 64'(pendingCnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port integer register file with a per-register scoreboard. Next generation of the core's register file.
- Serves the pipelined core: NUM_RD combinational read ports feed decode, one write port is fed by writeback, and the scoreboard tracks destinations with in-flight writes so decode can stall on RAW hazards.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  output  NUM_RD*DATA_WIDTH  packed read data, same packing
- rd_busy  output  NUM_RD  port i's register has a pending write
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_WIDTH  writeback destination
- wr_data  input  DATA_WIDTH  writeback value
- issue_en  input  1  instruction with destination issued this cycle
- issue_rd  input  ADDR_WIDTH  destination to mark pending
- pending_cnt  output  ADDR_WIDTH+1  number of registers currently busy
- sb_full  output  1  pending_cnt == NREGS-1

Behaviour:
- Reset is synchronous on the clk edge with rst=1.
  - All registers clear to 0, all busy bits clear, pending_cnt=0, sb_full=0.
  - Reset overrides any concurrent wr_en or issue_en.
  - A reset in the middle of outstanding writes discards them; a later wr_en to a formerly busy register just writes data.
- Reads are combinational from the array.
  - rd_addr==0 always returns 0 and rd_busy=0.
  - Read ports are independent; the same address on several ports returns identical data.
- Writes happen on the clk edge when wr_en=1 and wr_addr!=0; wr_data is visible on reads from the next cycle (without the optional bypass).
  - wr_addr==0 is ignored entirely (no data change, no scoreboard change).
- Scoreboard update, per register r≠0, applied at the clock edge:
  - set = issue_en && issue_rd==r
  - clr = wr_en && wr_addr==r
  - set && clr → busy stays 1 (new producer wins; the write still lands)
  - set only → 1; clr only → 0; neither → hold
  - issue_rd==0 → no effect
  - Re-issuing to an already busy register: busy stays 1 and the count does not change.
- rd_busy[i] = busy[rd_addr_i], combinational.
  - The current cycle's issue is not reflected until the next cycle.
  - The current cycle's clear is not reflected unless the optional bypass is enabled.
- pending_cnt is a registered counter, updated by +1, -1 or 0 per cycle from the net busy transitions, and always equals the popcount of the busy bits.
  - Never wraps: at most NREGS-1 registers can be busy.
- sb_full is combinational from pending_cnt.
- Write with no matching busy bit: data is written and the scoreboard is unchanged (no underflow).

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a same-cycle write is forwarded to reads.
  - If wr_en=1, wr_addr!=0 and wr_addr==rd_addr_i, then rd_data_i = wr_data.
  - If additionally not (issue_en && issue_rd==wr_addr), rd_busy_i = 0 in that cycle.
  - Write-to-read latency is 0 cycles.
- Undefined: no forwarding; reads see the new value and the cleared busy bit one cycle after the write edge.

Test Plan:
- Reset then read: rst high 1 cycle, read all 32 registers on both ports → every rd_data=0, rd_busy=0, pending_cnt=0.
- Write/read: wr x5=0xDEADBEEF, next cycle rd_addr0=5, rd_addr1=5 → both 0xDEADBEEF. wr x0=0x1234 → x0 reads 0, pending_cnt unchanged.
- Scoreboard basic: issue x7 → next cycle rd_busy=1 on port reading 7 and pending_cnt=1. wr x7=0x55 → next cycle rd_busy=0, pending_cnt=0, data 0x55.
- Simultaneous set/clear: with x9 busy, same cycle issue x9 and wr x9=0xA → next cycle busy still 1, pending_cnt unchanged, data 0xA. Issue x0 → no change.
- Fill: issue x1..x31 on consecutive cycles → pending_cnt=31 and sb_full=1. One write to x3 → pending_cnt=30, sb_full=0. Assert rst → everything clears in 1 cycle.
- Bypass: wr x4=0x77 while rd_addr0=4 (x4 previously busy, old value 0x11) → with RF_BYPASS_EN: rd_data0=0x77 and rd_busy0=0 in the same cycle. Without it: 0x11 and rd_busy0=1 that cycle, 0x77 and rd_busy0=0 the next.
